multi_cycle_control: RTL and testbench

Main control state machine for the multi-cycle MIPS core. It sequences each instruction through fetch, decode, execute, memory and write-back. In each state it drives datapath enables, mux selects and the 3-bit ALU operation class that the ALU control decoder turns into a 4-bit ALU operation. It sits between the instruction register, the shared instruction/data memory port and the ALU control block.

---
 rtl/multi_cycle_control.sv | 210 +++++++++++++++++++++
 tb/tb_multi_cycle_control.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/multi_cycle_control.sv
// Main control FSM of the multi-cycle MIPS core: sequences fetch, decode, execute,
// memory and write-back, driving datapath enables, mux selects and the ALU op class.
module multi_cycle_control (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opcode_i,
    input  logic       zero_i,
    input  logic       mem_ready_i,
    output logic       pc_write_o,
    output logic       i_or_d_o,
    output logic       mem_read_o,
    output logic       mem_write_o,
    output logic       ir_write_o,
    output logic       mem_to_reg_o,
    output logic       reg_dst_o,
    output logic       reg_write_o,
    output logic       alu_src_a_o,
    output logic [1:0] alu_src_b_o,
    output logic       imm_zero_ext_o,
    output logic [2:0] alu_op_o,
    output logic [1:0] pc_source_o,
    output logic       illegal_op_o,
    output logic [3:0] state_o
);

    localparam logic [5:0] OpRtype = 6'b000000;
    localparam logic [5:0] OpJ     = 6'b000010;
    localparam logic [5:0] OpBeq   = 6'b000100;
    localparam logic [5:0] OpBne   = 6'b000101;
    localparam logic [5:0] OpAddi  = 6'b001000;
    localparam logic [5:0] OpOri   = 6'b001101;
    localparam logic [5:0] OpLui   = 6'b001111;
    localparam logic [5:0] OpLw    = 6'b100011;
    localparam logic [5:0] OpSw    = 6'b101011;

    localparam logic [2:0] AluLui   = 3'b000;
    localparam logic [2:0] AluOr    = 3'b001;
    localparam logic [2:0] AluSub   = 3'b010;
    localparam logic [2:0] AluAdd   = 3'b100;
    localparam logic [2:0] AluRtype = 3'b111;

    localparam logic [1:0] SrcBReg   = 2'b00;
    localparam logic [1:0] SrcBFour  = 2'b01;
    localparam logic [1:0] SrcBImm   = 2'b10;
    localparam logic [1:0] SrcBImmSh = 2'b11;

    localparam logic [1:0] PcAlu    = 2'b00;
    localparam logic [1:0] PcAluOut = 2'b01;
    localparam logic [1:0] PcJump   = 2'b10;

    typedef enum logic [3:0] {
        StStart    = 4'd0,
        StFetch    = 4'd1,
        StDecode   = 4'd2,
        StMemAddr  = 4'd3,
        StMemRead  = 4'd4,
        StMemWb    = 4'd5,
        StMemWrite = 4'd6,
        StExecR    = 4'd7,
        StExecI    = 4'd8,
        StAluWb    = 4'd9,
        StBranch   = 4'd10,
        StJump     = 4'd11
    } state_e;

    state_e state_q, state_d;

    // State register; reset abandons any in-flight memory access.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StStart;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StStart: state_d = StFetch;
            StFetch: begin
                if (mem_ready_i) begin
                    state_d = StDecode;
                end
            end
            StDecode: begin
                case (opcode_i)
                    OpLw, OpSw:             state_d = StMemAddr;
                    OpRtype:                state_d = StExecR;
                    OpAddi, OpOri, OpLui:   state_d = StExecI;
                    OpBeq, OpBne:           state_d = StBranch;
                    OpJ:                    state_d = StJump;
                    default:                state_d = StFetch;
                endcase
            end
            StMemAddr: state_d = (opcode_i == OpSw) ? StMemWrite : StMemRead;
            StMemRead: begin
                if (mem_ready_i) begin
                    state_d = StMemWb;
                end
            end
            StMemWb: state_d = StFetch;
            StMemWrite: begin
                if (mem_ready_i) begin
                    state_d = StFetch;
                end
            end
            StExecR:  state_d = StAluWb;
            StExecI:  state_d = StAluWb;
            StAluWb:  state_d = StFetch;
            StBranch: state_d = StFetch;
            StJump:   state_d = StFetch;
            default:  state_d = StFetch;
        endcase
    end

    always_comb begin
        pc_write_o     = 1'b0;
        i_or_d_o       = 1'b0;
        mem_read_o     = 1'b0;
        mem_write_o    = 1'b0;
        ir_write_o     = 1'b0;
        mem_to_reg_o   = 1'b0;
        reg_dst_o      = 1'b0;
        reg_write_o    = 1'b0;
        alu_src_a_o    = 1'b0;
        alu_src_b_o    = SrcBReg;
        imm_zero_ext_o = 1'b0;
        alu_op_o       = AluLui;
        pc_source_o    = PcAlu;
        illegal_op_o   = 1'b0;
        case (state_q)
            StFetch: begin
                mem_read_o  = 1'b1;
                alu_src_b_o = SrcBFour;
                alu_op_o    = AluAdd;
                pc_source_o = PcAlu;
                ir_write_o  = mem_ready_i;
                pc_write_o  = mem_ready_i;
            end
            StDecode: begin
                // Branch target is precomputed into ALUOut while the opcode is decoded.
                alu_src_b_o = SrcBImmSh;
                alu_op_o    = AluAdd;
                case (opcode_i)
                    OpRtype, OpJ, OpBeq, OpBne, OpAddi, OpOri, OpLui, OpLw, OpSw:
                        illegal_op_o = 1'b0;
                    default:
                        illegal_op_o = 1'b1;
                endcase
            end
            StMemAddr: begin
                alu_src_a_o = 1'b1;
                alu_src_b_o = SrcBImm;
                alu_op_o    = AluAdd;
            end
            StMemRead: begin
                mem_read_o = 1'b1;
                i_or_d_o   = 1'b1;
            end
            StMemWb: begin
                reg_write_o  = 1'b1;
                mem_to_reg_o = 1'b1;
            end
            StMemWrite: begin
                mem_write_o = 1'b1;
                i_or_d_o    = 1'b1;
            end
            StExecR: begin
                alu_src_a_o = 1'b1;
                alu_src_b_o = SrcBReg;
                alu_op_o    = AluRtype;
            end
            StExecI: begin
                alu_src_a_o = 1'b1;
                alu_src_b_o = SrcBImm;
                case (opcode_i)
                    OpOri: begin
                        alu_op_o       = AluOr;
                        imm_zero_ext_o = 1'b1;
                    end
                    OpLui: begin
                        alu_op_o       = AluLui;
                        imm_zero_ext_o = 1'b1;
                    end
                    default: alu_op_o = AluAdd;
                endcase
            end
            StAluWb: begin
                reg_write_o = 1'b1;
                reg_dst_o   = (opcode_i == OpRtype);
            end
            StBranch: begin
                alu_src_a_o = 1'b1;
                alu_src_b_o = SrcBReg;
                alu_op_o    = AluSub;
                pc_source_o = PcAluOut;
                pc_write_o  = (opcode_i == OpBne) ? ~zero_i : zero_i;
            end
            StJump: begin
                pc_source_o = PcJump;
                pc_write_o  = 1'b1;
            end
            default: ;
        endcase
    end

    assign state_o = state_q;

endmodule

// File: tb/tb_multi_cycle_control.sv
// Randomized self-checking bench for multi_cycle_control against a per-instruction
// cycle-list reference model.
module tb_multi_cycle_control;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [5:0] opcode_i = 6'd0;
    logic       zero_i = 1'b0;
    logic       mem_ready_i = 1'b1;
    logic       pc_write_o, i_or_d_o, mem_read_o, mem_write_o, ir_write_o;
    logic       mem_to_reg_o, reg_dst_o, reg_write_o, alu_src_a_o;
    logic [1:0] alu_src_b_o;
    logic       imm_zero_ext_o;
    logic [2:0] alu_op_o;
    logic [1:0] pc_source_o;
    logic       illegal_op_o;
    logic [3:0] state_o;

    multi_cycle_control dut (
        .clk            (clk),
        .reset          (reset),
        .opcode_i       (opcode_i),
        .zero_i         (zero_i),
        .mem_ready_i    (mem_ready_i),
        .pc_write_o     (pc_write_o),
        .i_or_d_o       (i_or_d_o),
        .mem_read_o     (mem_read_o),
        .mem_write_o    (mem_write_o),
        .ir_write_o     (ir_write_o),
        .mem_to_reg_o   (mem_to_reg_o),
        .reg_dst_o      (reg_dst_o),
        .reg_write_o    (reg_write_o),
        .alu_src_a_o    (alu_src_a_o),
        .alu_src_b_o    (alu_src_b_o),
        .imm_zero_ext_o (imm_zero_ext_o),
        .alu_op_o       (alu_op_o),
        .pc_source_o    (pc_source_o),
        .illegal_op_o   (illegal_op_o),
        .state_o        (state_o)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       pc_write;
        logic       i_or_d;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       mem_to_reg;
        logic       reg_dst;
        logic       reg_write;
        logic       src_a;
        logic [1:0] src_b;
        logic       zext;
        logic [2:0] alu_op;
        logic [1:0] pc_src;
        logic       illegal;
    } out_t;

    typedef struct packed {
        logic [3:0] st;
        logic       rdy;
        out_t       o;
    } cyc_t;

    localparam logic [5:0] R = 6'h00, J = 6'h02, BEQ = 6'h04, BNE = 6'h05, ADDI = 6'h08;
    localparam logic [5:0] ORI = 6'h0d, LUI = 6'h0f, LW = 6'h23, SW = 6'h2b;

    out_t dut_o;
    assign dut_o = {pc_write_o, i_or_d_o, mem_read_o, mem_write_o, ir_write_o, mem_to_reg_o,
                    reg_dst_o, reg_write_o, alu_src_a_o, alu_src_b_o, imm_zero_ext_o,
                    alu_op_o, pc_source_o, illegal_op_o};

    cyc_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic is_legal(input logic [5:0] op);
        return op inside {R, J, BEQ, BNE, ADDI, ORI, LUI, LW, SW};
    endfunction

    task automatic add(input logic [3:0] st, input logic rdy, input out_t o);
        cyc_t c;
        c.st  = st;
        c.rdy = rdy;
        c.o   = o;
        exp_q.push_back(c);
    endtask

    // Expected cycle list of one instruction: sf fetch stalls, sm memory stalls.
    task automatic build(input logic [5:0] op, input logic z, input int sf, input int sm);
        out_t o;
        logic [3:0] mst;
        exp_q.delete();
        o = '0; o.mem_read = 1'b1; o.src_b = 2'b01; o.alu_op = 3'b100;
        for (int k = 0; k < sf; k++) add(4'd1, 1'b0, o);
        o.ir_write = 1'b1; o.pc_write = 1'b1;
        add(4'd1, 1'b1, o);
        o = '0; o.src_b = 2'b11; o.alu_op = 3'b100; o.illegal = !is_legal(op);
        add(4'd2, 1'b1, o);
        if (op == LW || op == SW) begin
            o = '0; o.src_a = 1'b1; o.src_b = 2'b10; o.alu_op = 3'b100;
            add(4'd3, 1'b1, o);
            o = '0; o.i_or_d = 1'b1;
            if (op == LW) o.mem_read = 1'b1; else o.mem_write = 1'b1;
            mst = (op == LW) ? 4'd4 : 4'd6;
            for (int k = 0; k < sm; k++) add(mst, 1'b0, o);
            add(mst, 1'b1, o);
            if (op == LW) begin
                o = '0; o.reg_write = 1'b1; o.mem_to_reg = 1'b1;
                add(4'd5, 1'b1, o);
            end
        end else if (op == R) begin
            o = '0; o.src_a = 1'b1; o.alu_op = 3'b111;
            add(4'd7, 1'b1, o);
            o = '0; o.reg_write = 1'b1; o.reg_dst = 1'b1;
            add(4'd9, 1'b1, o);
        end else if (op == ADDI || op == ORI || op == LUI) begin
            o = '0; o.src_a = 1'b1; o.src_b = 2'b10;
            o.alu_op = (op == ADDI) ? 3'b100 : ((op == ORI) ? 3'b001 : 3'b000);
            o.zext = (op != ADDI);
            add(4'd8, 1'b1, o);
            o = '0; o.reg_write = 1'b1;
            add(4'd9, 1'b1, o);
        end else if (op == BEQ || op == BNE) begin
            o = '0; o.src_a = 1'b1; o.alu_op = 3'b010; o.pc_src = 2'b01;
            o.pc_write = (op == BEQ) ? z : !z;
            add(4'd10, 1'b1, o);
        end else if (op == J) begin
            o = '0; o.pc_src = 2'b10; o.pc_write = 1'b1;
            add(4'd11, 1'b1, o);
        end
    endtask

    // Plays the first n expected cycles; the DUT must reach FETCH at the next negedge.
    task automatic run(input logic [5:0] op, input logic z, input int n);
        int lim;
        lim = (n < exp_q.size()) ? n : exp_q.size();
        for (int i = 0; i < lim; i++) begin
            @(negedge clk);
            opcode_i    = op;
            zero_i      = z;
            mem_ready_i = exp_q[i].rdy;
            #1;
            check($sformatf("op%02h c%0d state", op, i), {28'd0, state_o},
                  {28'd0, exp_q[i].st});
            check($sformatf("op%02h c%0d outs", op, i), {14'd0, dut_o}, {14'd0, exp_q[i].o});
        end
    endtask

    task automatic instr(input logic [5:0] op, input logic z, input int sf, input int sm);
        build(op, z, sf, sm);
        run(op, z, 1000);
    endtask

    initial begin
        logic [5:0] legal_ops [9];
        logic [5:0] op;
        int         idx;
        legal_ops = '{R, J, BEQ, BNE, ADDI, ORI, LUI, LW, SW};

        #2 reset = 1'b0;
        #1;
        check("reset_async state", {28'd0, state_o}, 32'd0);
        check("reset_async outs", {14'd0, dut_o}, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("post_release state", {28'd0, state_o}, 32'd0);

        instr(R, 1'b0, 0, 0);
        instr(LW, 1'b0, 0, 2);
        instr(BEQ, 1'b1, 0, 0);
        instr(BNE, 1'b1, 0, 0);
        instr(ORI, 1'b0, 0, 0);
        instr(LUI, 1'b0, 0, 0);
        instr(6'h3f, 1'b0, 0, 0);
        instr(BEQ, 1'b0, 1, 0);
        instr(BNE, 1'b0, 0, 0);
        instr(SW, 1'b0, 2, 1);
        instr(J, 1'b0, 0, 0);

        // Abort a stalled store with reset.
        build(SW, 1'b0, 0, 5);
        run(SW, 1'b0, 4);
        reset = 1'b0;
        #1;
        check("midreset state", {28'd0, state_o}, 32'd0);
        check("midreset outs", {14'd0, dut_o}, 32'd0);
        @(negedge clk);
        reset       = 1'b1;
        mem_ready_i = 1'b1;
        #1;
        check("midrelease state", {28'd0, state_o}, 32'd0);
        instr(ADDI, 1'b0, 0, 0);

        for (int n = 0; n < 120; n++) begin
            idx = $urandom_range(0, 10);
            if (idx < 9) op = legal_ops[idx];
            else op = 6'($urandom);
            instr(op, 1'($urandom), $urandom_range(0, 2), $urandom_range(0, 2));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
